// File: rtl/qrd_row_feeder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qrd_row_feeder_if : element load stream plus skewed QRD row-input bus      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface qrd_row_feeder_if #(
  parameter int DATA_W = 14
);
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] s_data_r;
  logic signed [DATA_W-1:0] s_data_i;

  logic                     in_ready;
  logic signed [DATA_W-1:0] row_in_1_r;
  logic signed [DATA_W-1:0] row_in_1_i;
  logic signed [DATA_W-1:0] row_in_2_r;
  logic signed [DATA_W-1:0] row_in_2_i;
  logic signed [DATA_W-1:0] row_in_3_r;
  logic signed [DATA_W-1:0] row_in_3_i;
  logic signed [DATA_W-1:0] row_in_4_r;
  logic signed [DATA_W-1:0] row_in_4_i;
  logic                     row_in_1_f;
  logic                     row_in_2_f;
  logic                     row_in_3_f;

  modport master (
    input  s_valid, s_data_r, s_data_i, in_ready,
    output s_ready,
    output row_in_1_r, row_in_1_i, row_in_2_r, row_in_2_i,
    output row_in_3_r, row_in_3_i, row_in_4_r, row_in_4_i,
    output row_in_1_f, row_in_2_f, row_in_3_f
  );

  modport slave (
    output s_valid, s_data_r, s_data_i, in_ready,
    input  s_ready,
    input  row_in_1_r, row_in_1_i, row_in_2_r, row_in_2_i,
    input  row_in_3_r, row_in_3_i, row_in_4_r, row_in_4_i,
    input  row_in_1_f, row_in_2_f, row_in_3_f
  );
endinterface
`default_nettype wire

// File: rtl/qrd_row_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qrd_row_feeder : buffers a 4x4 complex H, streams skewed [H | I] rows      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module qrd_row_feeder #(
  parameter int DATA_W  = 14,
  parameter int ONE_VAL = 1024,
  parameter int N       = 4,
  parameter int STEPS   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  qrd_row_feeder_if.master   bus,
  output logic               busy,
  output logic               done
);

  localparam int c_elems  = N * N;
  localparam int c_idx_w  = $clog2(c_elems);
  localparam int c_lg_n   = $clog2(N);
  localparam int c_step_w = $clog2(STEPS);
  localparam logic signed [DATA_W-1:0] c_one = DATA_W'(ONE_VAL);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t                    r_state;
  logic [c_idx_w-1:0]        r_cnt;
  logic [c_step_w-1:0]       r_step;
  logic                      r_s_ready;
  logic                      r_busy;
  logic                      r_done;
  logic signed [DATA_W-1:0]  r_h_r [c_elems];
  logic signed [DATA_W-1:0]  r_h_i [c_elems];
  logic signed [DATA_W-1:0]  r_row_r [N];
  logic signed [DATA_W-1:0]  r_row_i [N];
  logic [N-2:0]              r_flag;

  logic                      w_accept;
  logic                      w_last_load;
  logic                      w_consume;
  logic                      w_last_step;
  logic [c_step_w-1:0]       w_sel_step;
  logic [c_step_w-1:0]       w_off;
  logic [c_idx_w-1:0]        w_idx;
  logic signed [DATA_W-1:0]  w_row_r [N];
  logic signed [DATA_W-1:0]  w_row_i [N];
  logic [N-2:0]              w_flag;

  assign w_accept    = bus.s_valid && r_s_ready;
  assign w_last_load = w_accept && (r_cnt == c_idx_w'(c_elems - 1));
  assign w_consume   = (r_state == ST_STREAM) && bus.in_ready;
  assign w_last_step = w_consume && (r_step == c_step_w'(STEPS - 1));

  // The step about to be presented: 0 when leaving LOAD, s+1 on a consumed step.
  assign w_sel_step = (r_state == ST_STREAM) ? (r_step + c_step_w'(1)) : '0;

  // Row r carries Haug[r][step-r]; columns N..2N-1 are the identity half.
  always_comb begin
    w_off  = '0;
    w_idx  = '0;
    w_flag = '0;
    for (int r = 0; r < N; r++) begin
      w_row_r[r] = '0;
      w_row_i[r] = '0;
      w_off      = w_sel_step - c_step_w'(r);
      w_idx      = {c_lg_n'(r), w_off[c_lg_n-1:0]};
      if ((w_sel_step >= c_step_w'(r)) && (w_off < c_step_w'(2 * N))) begin
        if (w_off < c_step_w'(N)) begin
          w_row_r[r] = r_h_r[w_idx];
          w_row_i[r] = r_h_i[w_idx];
        end else if (w_off[c_lg_n-1:0] == c_lg_n'(r)) begin
          w_row_r[r] = c_one;
        end
      end
    end
    for (int k = 0; k < N - 1; k++) begin
      w_flag[k] = (w_sel_step == c_step_w'(2 * k));
    end
  end

  // Matrix buffer; contents after reset are irrelevant since a load always refills it.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_h_r[r_cnt] <= bus.s_data_r;
      r_h_i[r_cnt] <= bus.s_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_step    <= '0;
      r_s_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_flag    <= '0;
      for (int r = 0; r < N; r++) begin
        r_row_r[r] <= '0;
        r_row_i[r] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_s_ready <= 1'b1;
          if (w_accept) begin
            r_cnt   <= c_idx_w'(1);
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_last_load) begin
            r_s_ready <= 1'b0;
            r_cnt     <= '0;
            r_step    <= '0;
            r_flag    <= w_flag;
            for (int r = 0; r < N; r++) begin
              r_row_r[r] <= w_row_r[r];
              r_row_i[r] <= w_row_i[r];
            end
            r_state <= ST_STREAM;
          end else if (w_accept) begin
            r_cnt <= r_cnt + c_idx_w'(1);
          end
        end
        ST_STREAM: begin
          if (w_last_step) begin
            r_step <= '0;
            r_flag <= '0;
            r_done <= 1'b1;
            r_busy <= 1'b0;
            for (int r = 0; r < N; r++) begin
              r_row_r[r] <= '0;
              r_row_i[r] <= '0;
            end
            r_state <= ST_IDLE;
          end else if (w_consume) begin
            r_step <= w_sel_step;
            r_flag <= w_flag;
            for (int r = 0; r < N; r++) begin
              r_row_r[r] <= w_row_r[r];
              r_row_i[r] <= w_row_i[r];
            end
          end
        end
        default: begin
          r_s_ready <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready    = r_s_ready;
  assign bus.row_in_1_r = r_row_r[0];
  assign bus.row_in_1_i = r_row_i[0];
  assign bus.row_in_2_r = r_row_r[1];
  assign bus.row_in_2_i = r_row_i[1];
  assign bus.row_in_3_r = r_row_r[2];
  assign bus.row_in_3_i = r_row_i[2];
  assign bus.row_in_4_r = r_row_r[3];
  assign bus.row_in_4_i = r_row_i[3];
  assign bus.row_in_1_f = r_flag[0];
  assign bus.row_in_2_f = r_flag[1];
  assign bus.row_in_3_f = r_flag[2];
  assign busy           = r_busy;
  assign done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_qrd_row_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_qrd_row_feeder : directed bench for the QRD row feeder                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_qrd_row_feeder;
  localparam int DW = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic done;

  always #5 clk = ~clk;

  qrd_row_feeder_if #(.DATA_W(DW)) ifc ();

  qrd_row_feeder #(
    .DATA_W(DW), .ONE_VAL(1024), .N(4), .STEPS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.master), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;
  int nz;
  logic signed [DW-1:0] hr [16];
  logic signed [DW-1:0] hi [16];
  logic [114:0] cap [16];

  task automatic check(input logic [127:0] obs, input logic [127:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [114:0] out_vec();
    return {ifc.row_in_1_r, ifc.row_in_1_i, ifc.row_in_2_r, ifc.row_in_2_i,
            ifc.row_in_3_r, ifc.row_in_3_i, ifc.row_in_4_r, ifc.row_in_4_i,
            ifc.row_in_1_f, ifc.row_in_2_f, ifc.row_in_3_f};
  endfunction

  // Reference: row r at step s shows Haug[r][s-r], with Haug = [H | 1024*I].
  function automatic logic [114:0] exp_vec(input int s);
    logic [114:0] v;
    logic signed [DW-1:0] er, ei;
    int c;
    v = '0;
    for (int r = 0; r < 4; r++) begin
      c  = s - r;
      er = '0;
      ei = '0;
      if (c >= 0 && c < 4) begin
        er = hr[4*r+c];
        ei = hi[4*r+c];
      end else if (c >= 4 && c < 8 && (c - 4) == r) begin
        er = 14'sd1024;
      end
      v[114-28*r -: 14] = er;
      v[100-28*r -: 14] = ei;
    end
    v[2] = (s == 0);
    v[1] = (s == 2);
    v[0] = (s == 4);
    return v;
  endfunction

  task automatic set_ramp();
    for (int k = 0; k < 16; k++) begin
      hr[k] = DW'(16 * (k / 4) + (k % 4));
      hi[k] = DW'(-(16 * (k / 4) + (k % 4)));
    end
  endtask

  task automatic set_zero();
    for (int k = 0; k < 16; k++) begin
      hr[k] = '0;
      hi[k] = '0;
    end
  endtask

  task automatic set_mix();
    for (int k = 0; k < 16; k++) begin
      hr[k] = DW'(37 * k - 300);
      hi[k] = DW'(500 - 61 * k);
    end
  endtask

  task automatic send(input logic signed [DW-1:0] dr, input logic signed [DW-1:0] di);
    int w;
    w = 0;
    ifc.s_valid  = 1'b1;
    ifc.s_data_r = dr;
    ifc.s_data_i = di;
    while (ifc.s_ready !== 1'b1) begin
      if (w == 40) begin
        $display("FAIL load_wait: s_ready observed %b required 1", ifc.s_ready);
        $fatal(1, "load handshake stalled");
      end
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    ifc.s_valid = 1'b0;
  endtask

  task automatic load(input bit gaps, input int n);
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        ifc.s_valid  = 1'b0;
        ifc.s_data_r = DW'($urandom);
        ifc.s_data_i = DW'($urandom);
        @(posedge clk); #1;
      end
      send(hr[k], hi[k]);
      if (k == 0) check(128'(busy), 128'(1), "busy_after_first");
    end
    if (n == 16) check(128'(ifc.s_ready), 128'(0), "s_ready_drop");
  endtask

  task automatic stream(input logic [15:0] stall, input int stop_at, input bit junk,
                        input int exp_cyc);
    cyc = 0;
    for (int s = 0; s < 16; s++) begin
      cap[s] = out_vec();
      check(128'(cap[s]), 128'(exp_vec(s)), $sformatf("step%0d", s));
      if (s == stop_at) return;
      if (stall[s]) begin
        ifc.in_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          cyc++;
          check(128'(out_vec()), 128'(exp_vec(s)), $sformatf("stall_hold%0d", s));
        end
      end
      ifc.in_ready = 1'b1;
      if (junk) begin
        ifc.s_valid  = 1'($urandom_range(0, 1));
        ifc.s_data_r = DW'($urandom);
        ifc.s_data_i = DW'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      ifc.s_valid = 1'b0;
    end
    check(128'({done, busy, out_vec()}), 128'({1'b1, 1'b0, 115'b0}), "done_pulse");
    check(128'(cyc), 128'(exp_cyc), "done_latency");
    @(posedge clk); #1;
    check(128'({done, ifc.s_ready}), 128'(2'b01), "done_clear_ready");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.s_valid  = 1'b0;
    ifc.s_data_r = '0;
    ifc.s_data_i = '0;
    ifc.in_ready = 1'b1;
    #12;
    check(128'({out_vec(), ifc.s_ready, busy, done}), 128'(0), "reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check(128'(ifc.s_ready), 128'(1), "idle_s_ready");

    // Ramp matrix, no stalls
    set_ramp();
    load(1'b0, 16);
    stream(16'h0000, 99, 1'b0, 16);
    check(128'(cap[0][114:87]), 128'(0), "s0_row1");
    check(128'(cap[0][86:3]), 128'(0), "s0_rows234");
    check(128'(cap[0][2:0]), 128'(3'b100), "s0_flags");
    check(128'(cap[2][2:0]), 128'(3'b010), "s2_flags");
    check(128'(cap[3][114-:28]), 128'({14'(3), 14'(-3)}), "s3_row1");
    check(128'(cap[3][86-:28]), 128'({14'(18), 14'(-18)}), "s3_row2");
    check(128'(cap[3][58-:28]), 128'({14'(33), 14'(-33)}), "s3_row3");
    check(128'(cap[3][30-:28]), 128'({14'(48), 14'(-48)}), "s3_row4");
    check(128'(cap[4][114-:28]), 128'({14'(1024), 14'(0)}), "s4_row1");
    check(128'(cap[4][2:0]), 128'(3'b001), "s4_flags");

    // Same matrix, three-cycle stalls at steps 0, 7 and 15
    load(1'b0, 16);
    stream(16'h8081, 99, 1'b0, 25);

    // All-zero H exposes only the identity half
    set_zero();
    load(1'b0, 16);
    stream(16'h0000, 99, 1'b0, 16);
    nz = 0;
    for (int s = 0; s < 16; s++)
      for (int r = 0; r < 4; r++)
        if (cap[s][114-28*r -: 28] != 28'd0) nz++;
    check(128'(nz), 128'(4), "identity_nonzero_count");
    check(128'(cap[4][114-:28]), 128'({14'(1024), 14'(0)}), "ident_row1");
    check(128'(cap[6][86-:28]), 128'({14'(1024), 14'(0)}), "ident_row2");
    check(128'(cap[8][58-:28]), 128'({14'(1024), 14'(0)}), "ident_row3");
    check(128'(cap[10][30-:28]), 128'({14'(1024), 14'(0)}), "ident_row4");

    // Gappy load, s_valid noise during stream, then a second matrix
    set_ramp();
    load(1'b1, 16);
    stream(16'h0000, 99, 1'b1, 16);
    set_mix();
    load(1'b0, 16);
    stream(16'h0000, 99, 1'b0, 16);

    // Asynchronous reset while element 9 is offered
    load(1'b0, 9);
    ifc.s_valid  = 1'b1;
    ifc.s_data_r = hr[9];
    ifc.s_data_i = hi[9];
    #3 rst_n = 1'b0;
    #1;
    check(128'({out_vec(), ifc.s_ready, busy, done}), 128'(0), "rst_load_async");
    ifc.s_valid = 1'b0;
    @(posedge clk); #1;
    check(128'({out_vec(), ifc.s_ready, busy, done}), 128'(0), "rst_load_hold");
    #2 rst_n = 1'b1;
    set_ramp();
    load(1'b0, 16);
    stream(16'h0000, 99, 1'b0, 16);

    // Asynchronous reset while step 6 is presented
    set_mix();
    load(1'b0, 16);
    stream(16'h0000, 6, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    check(128'({out_vec(), ifc.s_ready, busy, done}), 128'(0), "rst_stream_async");
    @(posedge clk); #1;
    check(128'({out_vec(), ifc.s_ready, busy, done}), 128'(0), "rst_stream_hold");
    #2 rst_n = 1'b1;

    // Extreme values pass through bit-exact
    set_ramp();
    hr[0]  = -14'sd8192; hi[0]  = -14'sd8192;
    hr[1]  =  14'sd8191; hi[1]  =  14'sd8191;
    hr[15] = -14'sd8192; hi[15] =  14'sd8191;
    load(1'b0, 16);
    stream(16'h0000, 99, 1'b0, 16);
    check(128'(cap[0][114-:28]), 128'({14'h2000, 14'h2000}), "ext_neg_row1");
    check(128'(cap[1][114-:28]), 128'({14'h1fff, 14'h1fff}), "ext_pos_row1");
    check(128'(cap[6][30-:28]), 128'({14'h2000, 14'h1fff}), "ext_mixed_row4");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
